// File: rtl/button_ctrl_pkg.sv
// Shared types and helpers for the button debounce controller.
// Holds the FSM state type and the timer width helper.
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } btn_state_t;

  // Counter width for a modulo-n timer, never below one bit.
  function automatic int timer_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Modulo-MOD_VALUE up counter with synchronous clear and rollover flag.
// Ports: clk, reset, clear, increment -> rolling_over, count.
module settle_timer #(
  parameter int MOD_VALUE = 4,
  parameter int BIT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 increment,
  output logic                 rolling_over,
  output logic [BIT_WIDTH-1:0] count
);

  localparam logic [BIT_WIDTH-1:0] LAST =
    BIT_WIDTH'(MOD_VALUE - 1);

  assign rolling_over = increment && (count == LAST);

  // Clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      if (rolling_over) count <= '0;
      else              count <= count + BIT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/button_debounce_ctrl.sv
// Debounces one push-button: clean level, press/release/long pulses.
// Ports: clk, reset, btn_in -> btn_level, *_pulse, busy.
module button_debounce_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic busy
);

  localparam int DEB_W  = timer_width(DEBOUNCE_CYCLES);
  localparam int LONG_W = timer_width(LONG_PRESS_CYCLES);

  logic       sync1;
  logic       btn_sync;
  btn_state_t state;
  btn_state_t state_n;
  logic       long_fired;
  logic       fired_n;

  logic deb_clear, deb_inc, deb_roll;
  logic long_clear, long_inc, long_roll;
  logic press_n, release_n, long_n;

  logic [DEB_W-1:0]  deb_count;
  logic [LONG_W-1:0] long_count;
  logic              unused_counts;

  // Counts are only observed through the rollover flags.
  assign unused_counts = ^{deb_count, long_count};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync1    <= btn_in;
      btn_sync <= sync1;
    end
  end

  settle_timer #(
    .MOD_VALUE(DEBOUNCE_CYCLES),
    .BIT_WIDTH(DEB_W)
  ) u_deb_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (deb_clear),
    .increment   (deb_inc),
    .rolling_over(deb_roll),
    .count       (deb_count)
  );

  settle_timer #(
    .MOD_VALUE(LONG_PRESS_CYCLES),
    .BIT_WIDTH(LONG_W)
  ) u_long_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (long_clear),
    .increment   (long_inc),
    .rolling_over(long_roll),
    .count       (long_count)
  );

  always_comb begin
    state_n    = state;
    fired_n    = long_fired;
    press_n    = 1'b0;
    release_n  = 1'b0;
    long_n     = 1'b0;
    deb_clear  = 1'b0;
    deb_inc    = 1'b0;
    long_clear = 1'b0;
    long_inc   = 1'b0;
    unique case (state)
      S_LOW: begin
        if (btn_sync) begin
          state_n   = S_WAIT_HIGH;
          deb_clear = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        deb_inc = 1'b1;
        // A bounce beats a coincident rollover.
        if (!btn_sync) begin
          state_n = S_LOW;
        end else if (deb_roll) begin
          state_n = S_HIGH;
          press_n = 1'b1;
        end
      end
      S_HIGH: begin
        // Timer freezes once the long press has fired.
        long_inc = !long_fired;
        if (long_roll) begin
          long_n  = 1'b1;
          fired_n = 1'b1;
        end
        if (!btn_sync) begin
          state_n   = S_WAIT_LOW;
          deb_clear = 1'b1;
        end
      end
      S_WAIT_LOW: begin
        deb_inc = 1'b1;
        if (btn_sync) begin
          state_n = S_HIGH;
        end else if (deb_roll) begin
          state_n    = S_LOW;
          release_n  = 1'b1;
          long_clear = 1'b1;
          fired_n    = 1'b0;
        end
      end
      default: state_n = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_LOW;
      long_fired       <= 1'b0;
      btn_level        <= 1'b0;
      busy             <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      state            <= state_n;
      long_fired       <= fired_n;
      btn_level        <= (state_n == S_HIGH) ||
                          (state_n == S_WAIT_LOW);
      busy             <= (state_n == S_WAIT_HIGH) ||
                          (state_n == S_WAIT_LOW);
      press_pulse      <= press_n;
      release_pulse    <= release_n;
      long_press_pulse <= long_n;
    end
  end

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Self-checking bench for button_debounce_ctrl.
// Directed plan steps followed by randomized button traffic.
module tb_button_debounce_ctrl;
  import button_ctrl_pkg::*;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, press_pulse, release_pulse;
  logic long_press_pulse, busy;

  int checks = 0;
  int failures = 0;

  // Reference model: history of raw input, debounced level,
  // run of disagreeing samples, cycles held settled high.
  bit h0, h1;
  bit lvl;
  int run, held;
  bit fired;
  bit ep, er, el;

  int idx, press_at, rel_at, long_at;
  int n_press, n_rel, n_long;

  button_debounce_ctrl #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_in          (btn_in),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b t=%0t",
             tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag,
                         input int got,
                         input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d t=%0t",
             tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the
  // inputs as they will be sampled at that edge.
  task automatic model_step();
    bit s;
    s  = h1;
    ep = 0;
    er = 0;
    el = 0;
    if (reset) begin
      lvl   = 0;
      run   = 0;
      held  = 0;
      fired = 0;
    end else begin
      if (lvl && run == 0 && !fired) begin
        held++;
        if (held == L) begin
          el    = 1;
          fired = 1;
        end
      end
      if (s != lvl) begin
        run++;
        if (run == D + 1) begin
          lvl = ~lvl;
          run = 0;
          if (lvl) begin
            ep = 1;
          end else begin
            er    = 1;
            held  = 0;
            fired = 0;
          end
        end
      end else begin
        run = 0;
      end
    end
    h1 = reset ? 1'b0 : h0;
    h0 = reset ? 1'b0 : btn_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("btn_level", btn_level, lvl);
    chk("busy", busy, run > 0);
    chk("press", press_pulse, ep);
    chk("release", release_pulse, er);
    chk("long", long_press_pulse, el);
    if (press_pulse) begin
      if (press_at < 0) press_at = idx;
      n_press++;
    end
    if (release_pulse) begin
      if (rel_at < 0) rel_at = idx;
      n_rel++;
    end
    if (long_press_pulse) begin
      if (long_at < 0) long_at = idx;
      n_long++;
    end
    idx++;
  endtask

  task automatic phase_start();
    idx      = 0;
    press_at = -1;
    rel_at   = -1;
    long_at  = -1;
    n_press  = 0;
    n_rel    = 0;
    n_long   = 0;
  endtask

  initial begin
    h0 = 0;
    h1 = 0;
    lvl = 0;
    run = 0;
    held = 0;
    fired = 0;
    phase_start();

    // Reset state
    reset = 1'b1;
    btn_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Clean press held long enough for one long pulse
    phase_start();
    btn_in = 1'b1;
    repeat (60) tick();
    chk_int("press_latency", press_at, D + 2);
    chk_int("long_latency", long_at, D + 2 + L);
    chk_int("press_count", n_press, 1);
    chk_int("long_once", n_long, 1);

    // Release
    phase_start();
    btn_in = 1'b0;
    repeat (12) tick();
    chk_int("release_latency", rel_at, D + 2);
    chk_int("release_count", n_rel, 1);

    // New hold fires long press again
    phase_start();
    btn_in = 1'b1;
    repeat (20) tick();
    chk_int("long_again", long_at, D + 2 + L);
    chk_int("long_again_cnt", n_long, 1);
    btn_in = 1'b0;
    repeat (12) tick();

    // Press bounce
    phase_start();
    btn_in = 1'b1;
    repeat (3) tick();
    btn_in = 1'b0;
    repeat (10) tick();
    chk_int("bounce_no_press", n_press, 0);
    chk("bounce_level", btn_level, 1'b0);
    chk("bounce_busy", busy, 1'b0);
    chk_int("bounce_state", int'(dut.state), int'(S_LOW));

    // Release bounce at long count 3
    phase_start();
    btn_in = 1'b1;
    repeat (10) tick();
    btn_in = 1'b0;
    repeat (2) tick();
    btn_in = 1'b1;
    repeat (20) tick();
    chk_int("rbounce_no_rel", n_rel, 0);
    chk_int("rbounce_long", long_at, D + 2 + L + 2);
    chk("rbounce_level", btn_level, 1'b1);
    btn_in = 1'b0;
    repeat (12) tick();

    // Reset during debounce of a held button
    phase_start();
    btn_in = 1'b1;
    repeat (3) tick();
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    phase_start();
    repeat (12) tick();
    chk_int("rst_press_latency", press_at, D + 2);
    btn_in = 1'b0;
    repeat (12) tick();

    // Randomized traffic: runs of varied length, rare resets
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      btn_in = ~btn_in;
      if ($urandom_range(0, 3) == 0)
        len = $urandom_range(8, 25);
      else
        len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        reset = ($urandom_range(0, 99) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
